mem_arbiter: RTL and testbench

Shares one external memory bus between the instruction-fetch path (pc_reg/if_id) and the data path (mem stage). Requests are serialised with data-over-instruction priority. The block drives the pipeline stall vector that holds upstream stages while an access is outstanding. It also buffers a completed fetch so the fetch is not lost under a data stall, and aborts hung bus cycles with a watchdog.

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter_bus_wdog.sv | 15 +
 rtl/mem_arbiter.sv | 90 +++++++++
 tb/tb_mem_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encodings, stall vectors and watchdog width for the memory arbiter.
package mem_arbiter_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        D_WAIT = 3'd1,
        I_WAIT = 3'd2,
        D_DONE = 3'd3,
        I_DONE = 3'd4
    } state_t;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam int WDOG_W = 8;
endpackage

// File: rtl/mem_arbiter_bus_wdog.sv
// mem_arbiter_bus_wdog: bus wait counter that flags expiry once it reaches the loaded limit.
module mem_arbiter_bus_wdog import mem_arbiter_pkg::*; (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [WDOG_W-1:0] limit,
    output logic              expired
);
    logic [WDOG_W-1:0] cnt;
    always_ff @(posedge clk) begin
        cnt <= (!rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
    end
    assign expired = cnt == limit;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises fetch and data accesses onto one bus, data first, with fetch buffer and watchdog.
module mem_arbiter import mem_arbiter_pkg::*; #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_ready,
    input  logic        mem_ce,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [5:0]  stall,
    output logic        bus_err
);
    state_t state, next;
    logic ibuf_valid, expired, waiting, fin, fetch_go;

    assign waiting   = state == D_WAIT || state == I_WAIT;
    assign fin       = waiting && (bus_ack || expired);
    assign fetch_go  = if_ce && !ibuf_valid;
    assign bus_req   = waiting;
    assign mem_ready = state == D_DONE;
    assign stall     = (mem_ce && state != D_DONE) ? STALL_MEM : fetch_go ? STALL_IF : STALL_NONE;
    assign if_ready  = ibuf_valid && !stall[1];

    // The limit is one less than TIMEOUT because the count starts at 0 on the first wait cycle.
    mem_arbiter_bus_wdog u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting && !bus_ack),
        .limit   (WDOG_W'(TIMEOUT - 1)),
        .expired (expired)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = mem_ce ? D_WAIT : fetch_go ? I_WAIT : IDLE;
            D_WAIT:  next = fin ? D_DONE : D_WAIT;
            I_WAIT:  next = fin ? I_DONE : I_WAIT;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            bus_we     <= 1'b0;
            bus_sel    <= '0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            if_data    <= '0;
            mem_rdata  <= '0;
            ibuf_valid <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && mem_ce) begin
                bus_we    <= mem_we;
                bus_sel   <= mem_sel;
                bus_addr  <= mem_addr;
                bus_wdata <= mem_wdata;
            end else if (state == IDLE && fetch_go) begin
                bus_we    <= 1'b0;
                bus_sel   <= 4'hF;
                bus_addr  <= if_addr;
                bus_wdata <= '0;
            end
            if (fin && state == D_WAIT) mem_rdata <= bus_ack ? bus_rdata : '0;
            if (fin && state == I_WAIT) if_data <= bus_ack ? bus_rdata : '0;
            if (waiting && expired && !bus_ack) bus_err <= 1'b1;
            // A flushed fetch (if_ce low in I_DONE) never becomes valid.
            ibuf_valid <= (state == I_DONE && if_ce) || (ibuf_valid && !if_ready && if_ce);
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven cycle vectors plus hand-written sequences for the memory arbiter.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_ready;
    logic        mem_ce;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic [5:0]  stall;
    logic        bus_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_ce     (if_ce),
        .if_addr   (if_addr),
        .if_data   (if_data),
        .if_ready  (if_ready),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_sel   (mem_sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    // Inputs held for one cycle, outputs expected during that same cycle.
    typedef struct {
        logic        r, ic, mc, mw, ak;
        logic [31:0] ia, ma, md, rd;
        logic [3:0]  ms;
        logic        eq, ew, ir, mr, er;
        logic [3:0]  es;
        logic [31:0] ea, ed, id, mdv;
        logic [5:0]  st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] r, ic, ia, mc, mw, ms, ma, md, ak, rd,
                                input logic [31:0] eq, ew, es, ea, ed, st, ir, mr, id, mdv, er);
        vec_t v;
        v.r = r[0]; v.ic = ic[0]; v.ia = ia; v.mc = mc[0]; v.mw = mw[0]; v.ms = ms[3:0];
        v.ma = ma; v.md = md; v.ak = ak[0]; v.rd = rd;
        v.eq = eq[0]; v.ew = ew[0]; v.es = es[3:0]; v.ea = ea; v.ed = ed; v.st = st[5:0];
        v.ir = ir[0]; v.mr = mr[0]; v.id = id; v.mdv = mdv; v.er = er[0];
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst = v.r; if_ce = v.ic; if_addr = v.ia; mem_ce = v.mc; mem_we = v.mw; mem_sel = v.ms;
        mem_addr = v.ma; mem_wdata = v.md; bus_ack = v.ak; bus_rdata = v.rd;
    endtask

    task automatic check(input string name, input logic ok, input string detail);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", miscompares);
        $fatal(1);
    end

    initial begin
        vec_t v;
        logic ok;
        int n;
        // single fetch, ack after two wait cycles
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,0,0,       1,0,'hF,'h100,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,0,0,       1,0,'hF,'h100,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,1,'h34010020, 1,0,'hF,'h100,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h100,0,0,0,0,0,0,0,       0,0,0,0,0,'h00,1,0,'h34010020,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,0));
        // simultaneous fetch and data read: data first
        tbl.push_back(mk(1,1,'h104,1,0,'hF,'h200,0,0,0, 0,0,0,0,0,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h104,1,0,'hF,'h200,0,1,'h11112222, 1,0,'hF,'h200,0,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h104,1,0,'hF,'h200,0,0,0, 0,0,0,0,0,'h03,0,1,0,'h11112222,0));
        tbl.push_back(mk(1,1,'h104,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h104,0,0,0,0,0,1,'hAAAA0001, 1,0,'hF,'h104,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h104,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h104,0,0,0,0,0,0,0,       0,0,0,0,0,'h00,1,0,'hAAAA0001,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,0));
        // partial write, command stable through D_WAIT
        tbl.push_back(mk(1,0,0,1,1,'h3,'h300,'hDEADBEEF,0,0, 0,0,0,0,0,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,'h3,'h300,'hDEADBEEF,0,0, 1,1,'h3,'h300,'hDEADBEEF,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,'h3,'h300,'hDEADBEEF,0,0, 1,1,'h3,'h300,'hDEADBEEF,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,'h3,'h300,'hDEADBEEF,1,0, 1,1,'h3,'h300,'hDEADBEEF,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,1,'h3,'h300,'hDEADBEEF,0,0, 0,0,0,0,0,'h00,0,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,0));
        // hung bus: four wait cycles, then abort with zero data
        tbl.push_back(mk(1,0,0,1,0,'hF,'h400,0,0,'hFFFFFFFF, 0,0,0,0,0,'h1F,0,0,0,0,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,0,0,1,0,'hF,'h400,0,0,'hFFFFFFFF, 1,0,'hF,'h400,0,'h1F,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,1,0,'hF,'h400,0,0,'hFFFFFFFF, 0,0,0,0,0,'h00,0,1,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0,'hF,'h500,0,0,0,     0,0,0,0,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0,'hF,'h500,0,1,'h12345678, 1,0,'hF,'h500,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,1,0,'hF,'h500,0,0,0,     0,0,0,0,0,'h00,0,1,0,'h12345678,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,1));
        // fetch flushed mid-access, then a fresh fetch
        tbl.push_back(mk(1,1,'h600,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h600,0,0,0,0,0,0,0,       1,0,'hF,'h600,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,'hBAD0BAD0,  1,0,'hF,'h600,0,'h00,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h700,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h700,0,0,0,0,0,1,'h70707070, 1,0,'hF,'h700,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h700,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h700,0,0,0,0,0,0,0,       0,0,0,0,0,'h00,1,0,'h70707070,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,1));
        // data request arriving during I_WAIT
        tbl.push_back(mk(1,1,'h800,0,0,0,0,0,0,0,       0,0,0,0,0,'h03,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,0,0, 1,0,'hF,'h800,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,1,'h88888888, 1,0,'hF,'h800,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,0,0, 0,0,0,0,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,0,0, 0,0,0,0,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,1,'h99990000, 1,0,'hF,'h900,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,1,'h800,1,0,'hF,'h900,0,0,0, 0,0,0,0,0,'h00,1,1,'h88888888,'h99990000,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,1));
        // reset asserted during D_WAIT; late ack is ignored
        tbl.push_back(mk(1,0,0,1,0,'hF,'hA00,0,0,0,     0,0,0,0,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,0,'hF,'hA00,0,0,0,     1,0,'hF,'hA00,0,'h1F,0,0,0,0,1));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,1,'h5555AAAA,  0,0,0,0,0,'h00,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,0,0,0,0,0,0,           0,0,0,0,0,'h00,0,0,0,0,0));

        drive(tbl[0]);
        step();
        @(negedge clk);
        check("reset_state", bus_req === 1'b0 && bus_we === 1'b0 && bus_sel === 4'h0 && bus_addr === 32'h0 &&
              bus_wdata === 32'h0 && if_data === 32'h0 && mem_rdata === 32'h0 && if_ready === 1'b0 &&
              mem_ready === 1'b0 && bus_err === 1'b0 && stall === 6'h00,
              $sformatf("got req=%b we=%b sel=%h addr=%h wd=%h ifd=%h mrd=%h ifr=%b mr=%b err=%b stall=%b, want all zero",
                        bus_req, bus_we, bus_sel, bus_addr, bus_wdata, if_data, mem_rdata, if_ready, mem_ready, bus_err, stall));
        step();

        foreach (tbl[i]) begin
            v = tbl[i];
            drive(v);
            @(negedge clk);
            ok = bus_req === v.eq && stall === v.st && if_ready === v.ir && mem_ready === v.mr && bus_err === v.er &&
                 (!v.eq || (bus_we === v.ew && bus_sel === v.es && bus_addr === v.ea && bus_wdata === v.ed)) &&
                 (!v.ir || if_data === v.id) && (!v.mr || mem_rdata === v.mdv);
            check($sformatf("row%0d", i), ok,
                  $sformatf("got req=%b we=%b sel=%h addr=%h wd=%h stall=%b ifr=%b mr=%b ifd=%h mrd=%h err=%b want req=%b we=%b sel=%h addr=%h wd=%h stall=%b ifr=%b mr=%b ifd=%h mrd=%h err=%b",
                            bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stall, if_ready, mem_ready, if_data, mem_rdata, bus_err,
                            v.eq, v.ew, v.es, v.ea, v.ed, v.st, v.ir, v.mr, v.id, v.mdv, v.er));
            step();
        end

        // after the mid-access reset no command was latched, so the bus registers are back at zero
        drive(tbl[tbl.size() - 1]);
        @(negedge clk);
        check("post_reset_cmd", bus_addr === 32'h0 && bus_sel === 4'h0 && bus_we === 1'b0 && bus_wdata === 32'h0 &&
              mem_rdata === 32'h0 && bus_err === 1'b0,
              $sformatf("got addr=%h sel=%h we=%b wd=%h mrd=%h err=%b, want zeros", bus_addr, bus_sel, bus_we, bus_wdata, mem_rdata, bus_err));
        step();

        // bounded-wait fetch: one-cycle request latency, ready one cycle after I_DONE
        if_ce = 1'b1;
        if_addr = 32'h0000_0B00;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus_req && n < 5);
        check("fetch_req", bus_req === 1'b1 && bus_addr === 32'h0000_0B00 && n == 1,
              $sformatf("got req=%b addr=%h after %0d cycles, want req=1 addr=00000b00 after 1", bus_req, bus_addr, n));
        step();
        step();
        bus_ack = 1'b1;
        bus_rdata = 32'hCAFE_0001;
        step();
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        n = 0;
        while (!if_ready && n < 10) begin
            step();
            n++;
        end
        check("fetch_ready", if_ready === 1'b1 && if_data === 32'hCAFE_0001 && n == 1,
              $sformatf("got ifr=%b data=%h after %0d cycles, want ifr=1 data=cafe0001 after 1", if_ready, if_data, n));
        step();
        if_ce = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
